// File: rtl/koala_pkg.sv
// Shared constants for the Koala PRF: widths, round count, the table of state
// positions that absorb input bits, and the pi bit permutation.
package koala_pkg;

  localparam int SIZE     = 257;
  localparam int SIZE_DIN = 64;
  localparam int ROUNDS   = 8;
  localparam int IDX_W    = 9;
  localparam int N_INJ    = SIZE_DIN + 1;

  typedef logic [N_INJ-1:0][IDX_W-1:0] inj_tab_t;

  // Entry j is 12^(4j) mod 257; stepping by 12^4 = 20736 walks the powers.
  function automatic inj_tab_t gen_inj_tab();
    inj_tab_t    tab;
    int unsigned idx;
    tab = '0;
    idx = 1;
    for (int j = 0; j < N_INJ; j++) begin
      tab[j] = IDX_W'(idx);
      idx    = (idx * 32'd20736) % 32'(SIZE);
    end
    return tab;
  endfunction

  localparam inj_tab_t INJ_IDX = gen_inj_tab();

  function automatic int unsigned pi_idx(input int unsigned i);
    return (32'd12 * i) % 32'(SIZE);
  endfunction

endpackage

// File: rtl/koala_round.sv
// One combinational round of Koala-P: chi, iota, theta, then the pi bit shuffle.
module koala_round
  import koala_pkg::*;
(
  input  logic [SIZE-1:0] state_i,
  output logic [SIZE-1:0] state_o
);

  logic [SIZE-1:0] chi_s;
  logic [SIZE-1:0] iota_s;
  logic [SIZE-1:0] theta_s;

  genvar gi;

  for (gi = 0; gi < SIZE; gi++) begin : g_chi
    assign chi_s[gi] = state_i[gi] ^ (~state_i[(gi + 1) % SIZE] & state_i[(gi + 2) % SIZE]);
  end

  assign iota_s = chi_s ^ SIZE'(1);

  for (gi = 0; gi < SIZE; gi++) begin : g_theta
    assign theta_s[gi] = iota_s[gi] ^ iota_s[(gi + 3) % SIZE] ^ iota_s[(gi + 8) % SIZE];
  end

  for (gi = 0; gi < SIZE; gi++) begin : g_pi
    localparam int unsigned SRC = pi_idx(gi);
    assign state_o[gi] = theta_s[SRC];
  end

endmodule

// File: rtl/koala_prf_core.sv
// Koala keyed PRF core: key load, single-cycle absorb through the unrolled
// permutation, and a squeeze that snapshots the new state onto dout.
module koala_prf_core
  import koala_pkg::*;
(
  input  logic                clk,
  input  logic                arstn,
  input  logic                init,
  input  logic                sqz,
  input  logic [SIZE_DIN-1:0] din,
  input  logic                din_valid,
  input  logic [SIZE-1:0]     key,
  output logic [SIZE-1:0]     dout
);

  logic [SIZE-1:0] state_q, state_d;
  logic [SIZE-1:0] dout_q, dout_d;
  logic [SIZE-1:0] inj_vec;
  logic [SIZE-1:0] perm_in;
  logic [SIZE-1:0] perm_out;

  // A squeeze without valid data absorbs an all-zero block; the pad bit is always set.
  always_comb begin
    inj_vec = '0;
    for (int j = 0; j < SIZE_DIN; j++) begin
      inj_vec[INJ_IDX[j]] = inj_vec[INJ_IDX[j]] ^ (din[j] & din_valid);
    end
    inj_vec[INJ_IDX[SIZE_DIN]] = inj_vec[INJ_IDX[SIZE_DIN]] ^ 1'b1;
  end

  assign perm_in = state_q ^ inj_vec;

  genvar gi;
  for (gi = 0; gi < ROUNDS; gi++) begin : g_round
    logic [SIZE-1:0] s_in;
    logic [SIZE-1:0] s_out;
    if (gi == 0) begin : g_first
      assign s_in = perm_in;
    end else begin : g_chain
      assign s_in = g_round[gi-1].s_out;
    end
    koala_round u_round (
      .state_i (s_in),
      .state_o (s_out)
    );
  end

  assign perm_out = g_round[ROUNDS-1].s_out;

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    if (init) begin
      state_d = key;
    end else if (din_valid || sqz) begin
      state_d = perm_out;
      if (sqz) begin
        dout_d = perm_out;
      end
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_koala_prf_core.sv
// Directed bench for koala_prf_core against a bit-level software model of Koala-P.
module tb_koala_prf_core;

  localparam int N = 257;

  logic         clk = 1'b0;
  logic         arstn;
  logic         init;
  logic         sqz;
  logic         din_valid;
  logic [63:0]  din;
  logic [N-1:0] key;
  logic [N-1:0] dout;

  int n_vec = 0;
  int n_err = 0;
  int inj_pos [65];

  always #5 clk = ~clk;

  koala_prf_core dut (
    .clk       (clk),
    .arstn     (arstn),
    .init      (init),
    .sqz       (sqz),
    .din       (din),
    .din_valid (din_valid),
    .key       (key),
    .dout      (dout)
  );

  function automatic int pow12(input int e);
    int r;
    r = 1;
    for (int k = 0; k < e; k++) r = (r * 12) % 257;
    return r;
  endfunction

  function automatic logic [N-1:0] m_round(input logic [N-1:0] s);
    logic [N-1:0] a, b, r;
    for (int i = 0; i < N; i++) a[i] = s[i] ^ (~s[(i + 1) % N] & s[(i + 2) % N]);
    a[0] = ~a[0];
    for (int i = 0; i < N; i++) b[i] = a[i] ^ a[(i + 3) % N] ^ a[(i + 8) % N];
    for (int i = 0; i < N; i++) r[i] = b[(12 * i) % N];
    return r;
  endfunction

  function automatic logic [N-1:0] m_absorb(input logic [N-1:0] s, input logic [63:0] b);
    logic [N-1:0] t;
    t = s;
    for (int j = 0; j < 64; j++) t[inj_pos[j]] = t[inj_pos[j]] ^ b[j];
    t[inj_pos[64]] = t[inj_pos[64]] ^ 1'b1;
    for (int r = 0; r < 8; r++) t = m_round(t);
    return t;
  endfunction

  function automatic logic [N-1:0] rnd257();
    logic [287:0] t;
    for (int w = 0; w < 9; w++) t[w*32 +: 32] = $urandom;
    return t[N-1:0];
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: dout=%h required %h", tag, obs, exp);
    end
  endtask

  task automatic check_ne(input string tag, input logic [N-1:0] obs, input logic [N-1:0] other);
    n_vec++;
    assert (obs !== other) else begin
      n_err++;
      $error("FAIL %s: dout=%h required anything but %h", tag, obs, other);
    end
  endtask

  // init K, absorb b0, b1, squeeze with b2 (mid), squeeze with b3 (dout at exit)
  task automatic run_seq(input logic [N-1:0] k, input logic [63:0] b0, input logic [63:0] b1,
                         input logic [63:0] b2, input logic [63:0] b3, output logic [N-1:0] mid);
    init = 1'b1; key = k; step();
    init = 1'b0; din_valid = 1'b1; din = b0; step();
    din = b1; step();
    din = b2; sqz = 1'b1; step();
    mid = dout;
    din = b3; step();
    din_valid = 1'b0; sqz = 1'b0;
  endtask

  initial begin
    logic [N-1:0] ms, dexp, prev, kc, mid, exp_mid, exp_fin, g_out;
    logic [63:0]  b0, b1, b2, b3, g_b0, g_b1, g_b2, g_b3, bflip;
    logic [N-1:0] g_k;

    for (int j = 0; j < 65; j++) inj_pos[j] = pow12(4 * j);

    arstn = 1'b0; init = 1'b0; sqz = 1'b0; din_valid = 1'b0; din = '0; key = '0;
    step(); step();
    check("reset_dout", dout, '0);
    arstn = 1'b1;
    step();

    // zero key, idle, then a bare squeeze
    init = 1'b1; key = '0; step();
    init = 1'b0; step(); step(); step();
    sqz = 1'b1; step(); sqz = 1'b0;
    ms = m_absorb('0, 64'h0);
    check("sqz_zero_key", dout, ms);
    check_ne("sqz_zero_key_nonzero", dout, '0);
    dexp = ms;

    // absorb-only cycles leave dout alone; back-to-back squeezes each update it
    din_valid = 1'b1; din = 64'h0123_4567_89ab_cdef; ms = m_absorb(ms, din); step();
    check("absorb_hold_1", dout, dexp);
    din = 64'hfedc_ba98_7654_3210; ms = m_absorb(ms, din); step();
    check("absorb_hold_2", dout, dexp);
    din_valid = 1'b0; sqz = 1'b1; ms = m_absorb(ms, 64'h0); step();
    check("sqz_b2b_1", dout, ms);
    prev = ms;
    ms = m_absorb(ms, 64'h0); step();
    check("sqz_b2b_2", dout, ms);
    check_ne("sqz_b2b_distinct", dout, prev);
    sqz = 1'b0;
    dexp = ms;

    // init wins over concurrent absorb and squeeze
    kc = {1'b1, {8{32'ha5c3_0f96}}};
    init = 1'b1; key = kc; din_valid = 1'b1; din = 64'hdead_beef_cafe_f00d; sqz = 1'b1; step();
    init = 1'b0; din_valid = 1'b0; sqz = 1'b0;
    check("init_dout_hold", dout, dexp);
    sqz = 1'b1; step(); sqz = 1'b0;
    check("init_loads_key", dout, m_absorb(kc, 64'h0));

    // asynchronous reset mid-run, between clock edges
    din_valid = 1'b1; din = 64'h1111_2222_3333_4444; step();
    din_valid = 1'b0;
    #3 arstn = 1'b0;
    #1 check("async_reset_dout", dout, '0);
    init = 1'b1; key = kc; sqz = 1'b1; din_valid = 1'b1; step(); step();
    check("reset_overrides_inputs", dout, '0);
    init = 1'b0; sqz = 1'b0; din_valid = 1'b0; arstn = 1'b1; step();
    sqz = 1'b1; step(); sqz = 1'b0;
    check("reset_state_zero", dout, m_absorb('0, 64'h0));

    // full sequences with random key and blocks
    g_k = '0; g_b0 = '0; g_b1 = '0; g_b2 = '0; g_b3 = '0; g_out = '0;
    for (int it = 0; it < 100; it++) begin
      kc = rnd257(); b0 = rnd64(); b1 = rnd64(); b2 = rnd64(); b3 = rnd64();
      run_seq(kc, b0, b1, b2, b3, mid);
      exp_mid = m_absorb(m_absorb(m_absorb(kc, b0), b1), b2);
      exp_fin = m_absorb(exp_mid, b3);
      check("rand_mid", mid, exp_mid);
      check("rand_final", dout, exp_fin);
      if (it == 0) begin
        g_k = kc; g_b0 = b0; g_b1 = b1; g_b2 = b2; g_b3 = b3; g_out = exp_fin;
      end
    end

    // one flipped input bit changes the output
    bflip = g_b1 ^ (64'd1 << 17);
    run_seq(g_k, g_b0, bflip, g_b2, g_b3, mid);
    exp_fin = m_absorb(m_absorb(m_absorb(m_absorb(g_k, g_b0), bflip), g_b2), g_b3);
    check_ne("flip_differs", dout, g_out);
    check("flip_model", dout, exp_fin);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
